// File: rtl/matrix_mem_pkg.sv
// Shared definitions for the matrix operand store: default geometry,
// init pattern codes, init FSM states and the row-major index helper.
package matrix_pkg;

  localparam int DEF_ROWS  = 2;
  localparam int DEF_COLS  = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEED  = 5;

  // Init pattern codes; code 3 is reserved and fills like ZERO
  localparam logic [1:0] INIT_ZERO  = 2'd0;
  localparam logic [1:0] INIT_IDENT = 2'd1;
  localparam logic [1:0] INIT_SEED  = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } init_state_t;

  // Row-major linear index of element (row, col)
  function automatic int lin_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/matrix_mem_init.sv
// Init engine: walks every element in row-major order, one per cycle,
// producing the fill pattern. A ZERO pass is queued by reset and starts
// on the first clock after release; init_req starts a pass from IDLE.
module matrix_mem_init
  import matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEED  = DEF_SEED,
  parameter int RA_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CA_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_req,
  input  logic [1:0]       init_mode,
  output logic             busy,
  output logic             wr_ready,
  output logic             we,
  output logic [RA_W-1:0]  row,
  output logic [CA_W-1:0]  col,
  output logic [WIDTH-1:0] value
);

  init_state_t     state;
  logic            pending;
  logic [1:0]      mode_q;
  logic [RA_W-1:0] row_cnt;
  logic [CA_W-1:0] col_cnt;
  logic            last_elem;

  assign last_elem = (row_cnt == RA_W'(ROWS - 1)) && (col_cnt == CA_W'(COLS - 1));
  assign we        = (state == ST_FILL);
  assign row       = row_cnt;
  assign col       = col_cnt;

  // Fill sequencer: IDLE waits for the reset-queued pass or a request, FILL steps the element counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pending  <= 1'b1;
      mode_q   <= INIT_ZERO;
      row_cnt  <= '0;
      col_cnt  <= '0;
      busy     <= 1'b0;
      wr_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending || init_req) begin
            state    <= ST_FILL;
            mode_q   <= pending ? INIT_ZERO : init_mode;
            pending  <= 1'b0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end else begin
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end
        end
        ST_FILL: begin
          if (last_elem) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end else if (col_cnt == CA_W'(COLS - 1)) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pattern value for the element currently addressed by the counters
  always_comb begin
    value = '0;
    case (mode_q)
      INIT_IDENT: value = (int'(row_cnt) == int'(col_cnt)) ? WIDTH'(1) : '0;
      INIT_SEED:  value = WIDTH'(SEED + 2 * int'(row_cnt) + int'(col_cnt));
      default:    value = '0;
    endcase
  end

endmodule

// File: rtl/matrix_mem.sv
// ROWS x COLS operand store for the matrix multiplier: one write port with
// valid/ready shared with the init engine, two independent registered
// read ports, and a sticky flag for out-of-range addresses.
module matrix_mem
  import matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEED  = DEF_SEED,
  parameter int RA_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CA_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_req,
  input  logic [1:0]       init_mode,
  output logic             busy,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [RA_W-1:0]  wr_row,
  input  logic [CA_W-1:0]  wr_col,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd0_en,
  input  logic [RA_W-1:0]  rd0_row,
  input  logic [CA_W-1:0]  rd0_col,
  output logic [WIDTH-1:0] rd0_data,
  output logic             rd0_valid,
  input  logic             rd1_en,
  input  logic [RA_W-1:0]  rd1_row,
  input  logic [CA_W-1:0]  rd1_col,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_valid,
  output logic             addr_err
);

  localparam int DEPTH = ROWS * COLS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             fill_we;
  logic [RA_W-1:0]  fill_row;
  logic [CA_W-1:0]  fill_col;
  logic [WIDTH-1:0] fill_value;
  logic [IDX_W-1:0] fill_idx, wr_idx, rd0_idx, rd1_idx;
  logic             wr_ok, rd0_ok, rd1_ok, wr_fire;

  matrix_mem_init #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .RA_W  (RA_W),
    .CA_W  (CA_W)
  ) u_init (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .init_mode (init_mode),
    .busy      (busy),
    .wr_ready  (wr_ready),
    .we        (fill_we),
    .row       (fill_row),
    .col       (fill_col),
    .value     (fill_value)
  );

  assign fill_idx = IDX_W'(lin_index(int'(fill_row), int'(fill_col), COLS));
  assign wr_idx   = IDX_W'(lin_index(int'(wr_row), int'(wr_col), COLS));
  assign rd0_idx  = IDX_W'(lin_index(int'(rd0_row), int'(rd0_col), COLS));
  assign rd1_idx  = IDX_W'(lin_index(int'(rd1_row), int'(rd1_col), COLS));

  assign wr_ok   = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign rd0_ok  = (int'(rd0_row) < ROWS) && (int'(rd0_col) < COLS);
  assign rd1_ok  = (int'(rd1_row) < ROWS) && (int'(rd1_col) < COLS);
  assign wr_fire = wr_valid && wr_ready;

  // Array write: init engine owns the port during FILL, external writes only when accepted and in range
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_idx] <= fill_value;
    end else if (wr_fire && wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered reads (old data on a same-cycle write) and the sticky address error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd0_data  <= '0;
      rd0_valid <= 1'b0;
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      rd0_valid <= rd0_en;
      rd1_valid <= rd1_en;
      if (rd0_en) begin
        rd0_data <= rd0_ok ? mem[rd0_idx] : '0;
      end
      if (rd1_en) begin
        rd1_data <= rd1_ok ? mem[rd1_idx] : '0;
      end
      if ((wr_fire && !wr_ok) || (rd0_en && !rd0_ok) || (rd1_en && !rd1_ok)) begin
        addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_mem.sv
// Self-checking bench for matrix_mem on a non-square 3x4 array so that
// row/column mix-ups and out-of-range rows are both observable.
module tb_matrix_mem;

  localparam int ROWS  = 3;
  localparam int COLS  = 4;
  localparam int WIDTH = 8;
  localparam int SEED  = 5;
  localparam int RA_W  = 2;
  localparam int CA_W  = 2;
  localparam int N     = ROWS * COLS;

  logic             clk;
  logic             rst;
  logic             init_req;
  logic [1:0]       init_mode;
  logic             busy;
  logic             wr_valid;
  logic             wr_ready;
  logic [RA_W-1:0]  wr_row;
  logic [CA_W-1:0]  wr_col;
  logic [WIDTH-1:0] wr_data;
  logic             rd0_en, rd1_en;
  logic [RA_W-1:0]  rd0_row, rd1_row;
  logic [CA_W-1:0]  rd0_col, rd1_col;
  logic [WIDTH-1:0] rd0_data, rd1_data;
  logic             rd0_valid, rd1_valid;
  logic             addr_err;

  int errors = 0;
  int checks = 0;
  int model [N];

  matrix_mem #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .RA_W  (RA_W),
    .CA_W  (CA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .init_mode (init_mode),
    .busy      (busy),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .rd0_en    (rd0_en),
    .rd0_row   (rd0_row),
    .rd0_col   (rd0_col),
    .rd0_data  (rd0_data),
    .rd0_valid (rd0_valid),
    .rd1_en    (rd1_en),
    .rd1_row   (rd1_row),
    .rd1_col   (rd1_col),
    .rd1_data  (rd1_data),
    .rd1_valid (rd1_valid),
    .addr_err  (addr_err)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference contents after a complete init pass of the given mode
  function automatic void modelFill(input int mode);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (mode)
          1:       model[r*COLS+c] = (r == c) ? 1 : 0;
          2:       model[r*COLS+c] = (SEED + 2*r + c) % 256;
          default: model[r*COLS+c] = 0;
        endcase
  endfunction

  function automatic int expVal(input int r, input int c);
    if (r < ROWS && c < COLS) return model[r*COLS+c];
    return 0;
  endfunction

  // Counts busy cycles of one init pass; at pokeAt it tries a write and a second init_req
  task automatic waitFill(input string tag, input int pokeAt);
    int  cycles = 0;
    bit  seen   = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      init_req = 1'b0;
      wr_valid = 1'b0;
      if (busy) begin
        cycles++;
        seen = 1;
        if (cycles == pokeAt) begin
          checkOutput({tag, " wr_ready during fill"}, 32'(wr_ready), 0);
          init_req  = 1'b1;
          init_mode = 2'd1;
          wr_valid  = 1'b1;
          wr_row    = '0;
          wr_col    = '0;
          wr_data   = 8'hEE;
        end
      end else if (seen) begin
        break;
      end
    end
    checkOutput({tag, " fill length"}, 32'(cycles), N);
    checkOutput({tag, " wr_ready after fill"}, 32'(wr_ready), 1);
  endtask

  task automatic startInit(input string tag, input logic [1:0] mode, input int pokeAt);
    init_req  = 1'b1;
    init_mode = mode;
    waitFill(tag, pokeAt);
  endtask

  task automatic readPair(input string tag, input int r0, input int c0, input int r1, input int c1);
    int e0, e1;
    e0 = expVal(r0, c0);
    e1 = expVal(r1, c1);
    rd0_en = 1'b1; rd0_row = RA_W'(r0); rd0_col = CA_W'(c0);
    rd1_en = 1'b1; rd1_row = RA_W'(r1); rd1_col = CA_W'(c1);
    @(negedge clk);
    rd0_en = 1'b0;
    rd1_en = 1'b0;
    checkOutput($sformatf("%s rd0 (%0d,%0d)", tag, r0, c0), 32'(rd0_data), e0);
    checkOutput($sformatf("%s rd1 (%0d,%0d)", tag, r1, c1), 32'(rd1_data), e1);
    checkOutput({tag, " rd0_valid"}, 32'(rd0_valid), 1);
    checkOutput({tag, " rd1_valid"}, 32'(rd1_valid), 1);
  endtask

  task automatic readAll(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        readPair(tag, r, c, ROWS-1-r, COLS-1-c);
  endtask

  // Write one element while port 0 reads the same element and port 1 reads another
  task automatic applyStimulus(input string tag, input int wr, input int wc, input int wd, input int r1, input int c1);
    int e0, e1;
    e0 = expVal(wr, wc);
    e1 = expVal(r1, c1);
    checkOutput({tag, " wr_ready idle"}, 32'(wr_ready), 1);
    wr_valid = 1'b1; wr_row = RA_W'(wr); wr_col = CA_W'(wc); wr_data = WIDTH'(wd);
    rd0_en = 1'b1; rd0_row = RA_W'(wr); rd0_col = CA_W'(wc);
    rd1_en = 1'b1; rd1_row = RA_W'(r1); rd1_col = CA_W'(c1);
    @(negedge clk);
    wr_valid = 1'b0;
    rd0_en   = 1'b0;
    rd1_en   = 1'b0;
    checkOutput({tag, " rd0 read-first"}, 32'(rd0_data), e0);
    checkOutput({tag, " rd1 read-first"}, 32'(rd1_data), e1);
    if (wr < ROWS && wc < COLS) model[wr*COLS+wc] = wd % 256;
  endtask

  // Directed sequence with randomized write/read traffic in the middle
  initial begin
    int last;
    rst = 1'b0; init_req = 1'b0; init_mode = 2'd0;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    rd0_en = 1'b0; rd0_row = '0; rd0_col = '0;
    rd1_en = 1'b0; rd1_row = '0; rd1_col = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset wr_ready", 32'(wr_ready), 0);
    checkOutput("reset rd0_data", 32'(rd0_data), 0);
    checkOutput("reset rd1_valid", 32'(rd1_valid), 0);
    checkOutput("reset addr_err", 32'(addr_err), 0);

    rst = 1'b1;
    waitFill("auto zero", 0);
    modelFill(0);
    readAll("zero");

    startInit("seed", 2'd2, N-3);
    modelFill(2);
    readAll("seed");

    startInit("ident", 2'd1, 0);
    modelFill(1);
    readAll("ident");

    applyStimulus("a5", 1, 0, 8'hA5, 1, 0);
    readPair("a5 after", 1, 0, 1, 0);
    @(negedge clk);
    checkOutput("hold rd0_data", 32'(rd0_data), 8'hA5);
    checkOutput("hold rd0_valid", 32'(rd0_valid), 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus("rand", int'($urandom_range(0, ROWS-1)), int'($urandom_range(0, COLS-1)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, ROWS-1)),
                    int'($urandom_range(0, COLS-1)));
    end
    readAll("after writes");

    startInit("reserved", 2'd3, 0);
    modelFill(0);
    readAll("reserved");

    applyStimulus("pre oor", 2, 3, 8'h5A, 2, 3);
    readPair("pre oor", 2, 3, 2, 3);
    checkOutput("addr_err clean", 32'(addr_err), 0);
    readPair("oor", ROWS, 1, 2, 3);
    checkOutput("addr_err after oor read", 32'(addr_err), 1);
    last = expVal(2, 3);
    readPair("post oor", 2, 3, 2, 3);

    init_req = 1'b1; init_mode = 2'd2;
    repeat (5) begin
      @(negedge clk);
      init_req = 1'b0;
    end
    checkOutput("mid fill busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    checkOutput("mid rst busy", 32'(busy), 0);
    checkOutput("mid rst wr_ready", 32'(wr_ready), 0);
    checkOutput("mid rst rd0_data", 32'(rd0_data), 0);
    checkOutput("mid rst rd1_data", 32'(rd1_data), 0);
    checkOutput("mid rst addr_err", 32'(addr_err), 0);
    checkOutput("pre rst data was live", 32'(last), 8'h5A);
    @(negedge clk);
    rst = 1'b1;
    waitFill("restart", 0);
    modelFill(0);
    readAll("restart");

    wr_valid = 1'b1; wr_row = RA_W'(ROWS); wr_col = '0; wr_data = 8'h77;
    @(negedge clk);
    wr_valid = 1'b0;
    checkOutput("addr_err after oor write", 32'(addr_err), 1);
    readAll("after oor write");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
